// File: rtl/mmio_bus_initiator.sv
// MMIO bus initiator: buffers read/write commands in a small FIFO, issues each as a
// single-cycle registered bus strobe, and returns read data on a valid/ready port.
module mmio_bus_initiator #(
  parameter int FIFO_AW = 2,
  parameter int RD_LAT  = 0
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic        cmd_write,
  input  logic [20:0] cmd_addr,
  input  logic [31:0] cmd_wr_data,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_data,
  output logic        mmio_cs,
  output logic        mmio_wr,
  output logic        mmio_rd,
  output logic [20:0] mmio_addr,
  output logic [31:0] mmio_wr_data,
  input  logic [31:0] mmio_rd_data,
  output logic        busy,
  output logic [15:0] txn_count
);

  // state  | meaning
  // IDLE   | no bus activity; pops the FIFO head when one is present
  // ISSUE  | strobe on the bus this cycle; writes may chain back-to-back
  // RWAIT  | read strobe done, counting down RD_LAT before sampling read data
  // RESP   | read data held on rsp_data until the consumer takes it
  typedef enum logic [1:0] {IDLE, ISSUE, RWAIT, RESP} state_e;

  typedef struct packed {
    logic        write;
    logic [20:0] addr;
    logic [31:0] data;
  } cmd_t;

  localparam int DEPTH = 1 << FIFO_AW;
  localparam logic [2:0] LAT_M1 = (RD_LAT > 0) ? 3'(RD_LAT - 1) : 3'd0;

  cmd_t             mem_q [DEPTH];
  logic [FIFO_AW:0] wr_ptr_q, rd_ptr_q;
  logic             full, empty, push, pop;
  cmd_t             head;

  state_e      state_q, state_d;
  logic        cs_q, cs_d, wr_q, wr_d, rd_q, rd_d;
  logic [20:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic [31:0] rdata_q, rdata_d;
  logic [2:0]  cnt_q, cnt_d;
  logic [15:0] txn_q, txn_d;
  logic        load;

  assign empty = (wr_ptr_q == rd_ptr_q);
  assign full  = (wr_ptr_q[FIFO_AW] != rd_ptr_q[FIFO_AW]) &&
                 (wr_ptr_q[FIFO_AW-1:0] == rd_ptr_q[FIFO_AW-1:0]);
  assign push  = cmd_valid & ~full;
  assign head  = mem_q[rd_ptr_q[FIFO_AW-1:0]];

  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q[FIFO_AW-1:0]] <= '{cmd_write, cmd_addr, cmd_wr_data};
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
    end
  end

  always_comb begin
    state_d = state_q;
    load    = 1'b0;
    pop     = 1'b0;
    cs_d    = 1'b0;
    wr_d    = 1'b0;
    rd_d    = 1'b0;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;
    cnt_d   = cnt_q;
    txn_d   = txn_q;

    case (state_q)
      IDLE: begin
        if (!empty) begin
          load    = 1'b1;
          state_d = ISSUE;
        end
      end
      ISSUE: begin
        if (wr_q) begin
          txn_d = txn_q + 16'd1;
          if (!empty) load = 1'b1;
          else        state_d = IDLE;
        end else if (RD_LAT == 0) begin
          rdata_d = mmio_rd_data;
          state_d = RESP;
        end else begin
          cnt_d   = LAT_M1;
          state_d = RWAIT;
        end
      end
      RWAIT: begin
        if (cnt_q == 3'd0) begin
          rdata_d = mmio_rd_data;
          state_d = RESP;
        end else begin
          cnt_d = cnt_q - 3'd1;
        end
      end
      RESP: begin
        if (rsp_ready) begin
          txn_d   = txn_q + 16'd1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    // Write data is only loaded for writes so the bus keeps its last written value.
    if (load) begin
      pop    = 1'b1;
      cs_d   = 1'b1;
      wr_d   = head.write;
      rd_d   = ~head.write;
      addr_d = head.addr;
      if (head.write) wdata_d = head.data;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= IDLE;
      cs_q    <= 1'b0;
      wr_q    <= 1'b0;
      rd_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      cnt_q   <= '0;
      txn_q   <= '0;
    end else begin
      state_q <= state_d;
      cs_q    <= cs_d;
      wr_q    <= wr_d;
      rd_q    <= rd_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
      cnt_q   <= cnt_d;
      txn_q   <= txn_d;
    end
  end

  assign cmd_ready    = ~full;
  assign rsp_valid    = (state_q == RESP);
  assign rsp_data     = rdata_q;
  assign mmio_cs      = cs_q;
  assign mmio_wr      = wr_q;
  assign mmio_rd      = rd_q;
  assign mmio_addr    = addr_q;
  assign mmio_wr_data = wdata_q;
  assign busy         = (state_q != IDLE) | ~empty;
  assign txn_count    = txn_q;

endmodule

// File: tb/tb_mmio_bus_initiator.sv
// Directed bench: one initiator with RD_LAT=0 and one with RD_LAT=3 sharing clock/reset.
module tb_mmio_bus_initiator;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  // RD_LAT = 0 instance
  logic        cv0, cr0, cw0, rv0, rr0, cs0, wr0, rd0, busy0;
  logic [20:0] ca0, ma0;
  logic [31:0] cd0, rdat0, mwd0, mrd0;
  logic [15:0] txn0;

  // RD_LAT = 3 instance
  logic        cv1, cr1, cw1, rv1, rr1, cs1, wr1, rd1, busy1;
  logic [20:0] ca1, ma1;
  logic [31:0] cd1, rdat1, mwd1, mrd1;
  logic [15:0] txn1;

  int checks = 0;
  int errors = 0;

  assign mrd0 = (ma0 == 21'h00080) ? 32'h12345678 : 32'hFFFF0000;

  mmio_bus_initiator #(.FIFO_AW(2), .RD_LAT(0)) u_dut0 (
    .clk(clk), .reset(reset),
    .cmd_valid(cv0), .cmd_ready(cr0), .cmd_write(cw0), .cmd_addr(ca0), .cmd_wr_data(cd0),
    .rsp_valid(rv0), .rsp_ready(rr0), .rsp_data(rdat0),
    .mmio_cs(cs0), .mmio_wr(wr0), .mmio_rd(rd0), .mmio_addr(ma0), .mmio_wr_data(mwd0),
    .mmio_rd_data(mrd0), .busy(busy0), .txn_count(txn0)
  );

  mmio_bus_initiator #(.FIFO_AW(2), .RD_LAT(3)) u_dut1 (
    .clk(clk), .reset(reset),
    .cmd_valid(cv1), .cmd_ready(cr1), .cmd_write(cw1), .cmd_addr(ca1), .cmd_wr_data(cd1),
    .rsp_valid(rv1), .rsp_ready(rr1), .rsp_data(rdat1),
    .mmio_cs(cs1), .mmio_wr(wr1), .mmio_rd(rd1), .mmio_addr(ma1), .mmio_wr_data(mwd1),
    .mmio_rd_data(mrd1), .busy(busy1), .txn_count(txn1)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  initial begin
    logic stray;
    logic timeout;
    reset = 1'b0;
    cv0 = 1'b0; cw0 = 1'b0; ca0 = '0; cd0 = '0; rr0 = 1'b0;
    cv1 = 1'b0; cw1 = 1'b0; ca1 = '0; cd1 = '0; rr1 = 1'b0;
    mrd1 = 32'h0;

    // Reset state
    step(); step();
    chk("rst_cs",     32'(cs0), 32'h0);
    chk("rst_rvalid", 32'(rv0), 32'h0);
    chk("rst_rdata",  rdat0, 32'h0);
    chk("rst_txn",    32'(txn0), 32'h0);
    chk("rst_busy",   32'(busy0), 32'h0);
    chk("rst_ready",  32'(cr0), 32'h1);
    chk("rst_addr",   32'(ma0), 32'h0);
    reset = 1'b1;
    step();

    // Single write: strobe two cycles after acceptance, exactly one cycle long
    cv0 = 1'b1; cw0 = 1'b1; ca0 = 21'h000C4; cd0 = 32'hDEADBEEF;
    step();
    cv0 = 1'b0;
    chk("w1_busy_pre", 32'(busy0), 32'h1);
    chk("w1_cs_pre",   32'(cs0), 32'h0);
    step();
    chk("w1_strobe", {29'h0, cs0, wr0, rd0}, 32'h6);
    chk("w1_addr",   32'(ma0), 32'h000C4);
    chk("w1_wdata",  mwd0, 32'hDEADBEEF);
    step();
    chk("w1_cs_post", 32'(cs0), 32'h0);
    chk("w1_txn",     32'(txn0), 32'h1);
    chk("w1_busy",    32'(busy0), 32'h0);

    // Read, RD_LAT=0: rsp_valid three cycles after acceptance, held under backpressure
    cv0 = 1'b1; cw0 = 1'b0; ca0 = 21'h00080; rr0 = 1'b0;
    step();
    cv0 = 1'b0;
    chk("r0_rv_t1", 32'(rv0), 32'h0);
    step();
    chk("r0_strobe", {29'h0, cs0, wr0, rd0}, 32'h5);
    chk("r0_addr",   32'(ma0), 32'h00080);
    chk("r0_rv_t2",  32'(rv0), 32'h0);
    step();
    chk("r0_rv_t3", 32'(rv0), 32'h1);
    chk("r0_rdata", rdat0, 32'h12345678);
    for (int i = 0; i < 5; i++) begin
      step();
      chk("r0_hold_rv", 32'(rv0), 32'h1);
      chk("r0_hold_rd", rdat0, 32'h12345678);
      chk("r0_hold_cs", 32'(cs0), 32'h0);
    end
    rr0 = 1'b1;
    step();
    rr0 = 1'b0;
    chk("r0_rv_done", 32'(rv0), 32'h0);
    chk("r0_txn",     32'(txn0), 32'h2);

    // FIFO full: a read parked in RESP stalls the bus while four writes fill the FIFO
    cv0 = 1'b1; cw0 = 1'b0; ca0 = 21'h00080;
    step();
    for (int i = 0; i < 4; i++) begin
      cw0 = 1'b1; ca0 = 21'(32'h100 + 4 * i); cd0 = 32'hC0DE0000 + 32'(i);
      step();
    end
    chk("full_ready", 32'(cr0), 32'h0);
    chk("full_rv",    32'(rv0), 32'h1);
    ca0 = 21'h00110; cd0 = 32'hC0DE0004;
    step();
    chk("full_ready2", 32'(cr0), 32'h0);
    step();
    chk("full_ready3", 32'(cr0), 32'h0);
    chk("full_nobus",  32'(cs0), 32'h0);
    rr0 = 1'b1;
    step();
    rr0 = 1'b0;
    chk("full_rsp_done", 32'(rv0), 32'h0);
    chk("full_ready4",   32'(cr0), 32'h0);
    for (int k = 0; k < 6; k++) begin
      step();
      chk("b2b_strobe", {29'h0, cs0, wr0, rd0}, 32'h6);
      chk("b2b_addr",   32'(ma0), 32'h100 + 32'(4 * k));
      chk("b2b_wdata",  mwd0, 32'hC0DE0000 + 32'(k));
      // Head popped while full: the offered push must have been refused
      if (k == 0) chk("full_pop_push", 32'(cr0), 32'h1);
      if (k == 1) begin ca0 = 21'h00114; cd0 = 32'hC0DE0005; end
      if (k == 2) cv0 = 1'b0;
    end
    step();
    chk("b2b_cs_end", 32'(cs0), 32'h0);
    chk("b2b_txn",    32'(txn0), 32'd9);
    chk("b2b_busy",   32'(busy0), 32'h0);

    // RD_LAT=3, write/read/write: data sampled exactly three cycles after the strobe
    rr1 = 1'b0;
    cv1 = 1'b1; cw1 = 1'b1; ca1 = 21'h00200; cd1 = 32'h11111111;
    step();
    cw1 = 1'b0; ca1 = 21'h00204;
    step();
    chk("l3_w_strobe", {29'h0, cs1, wr1, rd1}, 32'h6);
    chk("l3_w_addr",   32'(ma1), 32'h00200);
    cw1 = 1'b1; ca1 = 21'h00208; cd1 = 32'h22222222;
    step();
    cv1 = 1'b0;
    mrd1 = 32'hBAD00001;
    chk("l3_r_strobe", {29'h0, cs1, wr1, rd1}, 32'h5);
    chk("l3_r_addr",   32'(ma1), 32'h00204);
    step();
    mrd1 = 32'hBAD00002;
    chk("l3_rwait_cs",   {30'h0, cs1, rd1}, 32'h0);
    chk("l3_rwait_addr", 32'(ma1), 32'h00204);
    step();
    mrd1 = 32'hBAD00003;
    chk("l3_rv_early", 32'(rv1), 32'h0);
    step();
    mrd1 = 32'h600DF00D;
    step();
    mrd1 = 32'hBAD00005;
    chk("l3_rv",    32'(rv1), 32'h1);
    chk("l3_rdata", rdat1, 32'h600DF00D);
    step();
    chk("l3_hold_cs", 32'(cs1), 32'h0);
    step();
    chk("l3_hold_rd", rdat1, 32'h600DF00D);
    rr1 = 1'b1;
    step();
    rr1 = 1'b0;
    chk("l3_rsp_done", 32'(rv1), 32'h0);
    chk("l3_w2_wait",  32'(cs1), 32'h0);
    step();
    chk("l3_w2_strobe", {29'h0, cs1, wr1, rd1}, 32'h6);
    chk("l3_w2_addr",   32'(ma1), 32'h00208);
    chk("l3_w2_wdata",  mwd1, 32'h22222222);
    step();
    chk("l3_txn",  32'(txn1), 32'h3);
    chk("l3_busy", 32'(busy1), 32'h0);

    // Reset during RWAIT with a write queued behind the read
    cv1 = 1'b1; cw1 = 1'b0; ca1 = 21'h00204;
    step();
    cw1 = 1'b1; ca1 = 21'h0020C; cd1 = 32'h33333333;
    step();
    cv1 = 1'b0;
    step();
    chk("mr_in_rwait", {30'h0, cs1, busy1}, 32'h1);
    reset = 1'b0;
    step();
    reset = 1'b1;
    chk("mr_rv",    32'(rv1), 32'h0);
    chk("mr_csrd",  {30'h0, cs1, rd1}, 32'h0);
    chk("mr_busy",  32'(busy1), 32'h0);
    chk("mr_txn",   32'(txn1), 32'h0);
    chk("mr_rdata", rdat1, 32'h0);
    rr1 = 1'b1;
    stray = 1'b0;
    for (int i = 0; i < 10; i++) begin
      step();
      if (rv1 || cs1) stray = 1'b1;
    end
    rr1 = 1'b0;
    chk("mr_no_activity", 32'(stray), 32'h0);

    // txn_count wrap on the RD_LAT=0 instance (also cleared by the reset above)
    chk("wrap_start", 32'(txn0), 32'h0);
    cv0 = 1'b1; cw0 = 1'b1; ca0 = 21'h00300; cd0 = 32'h0;
    for (int i = 0; i < 65535; i++) step();
    cv0 = 1'b0;
    timeout = 1'b1;
    for (int i = 0; i < 50; i++) begin
      step();
      if (!busy0) begin timeout = 1'b0; break; end
    end
    chk("wrap_drain1", 32'(timeout), 32'h0);
    chk("wrap_ffff",   32'(txn0), 32'h0000FFFF);
    cv0 = 1'b1;
    step();
    cv0 = 1'b0;
    timeout = 1'b1;
    for (int i = 0; i < 50; i++) begin
      step();
      if (!busy0) begin timeout = 1'b0; break; end
    end
    chk("wrap_drain2", 32'(timeout), 32'h0);
    chk("wrap_zero",   32'(txn0), 32'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
